ahb_master_ctrl: RTL and testbench
==================================

AHB_MASTER_CTRL -- requirements
Module: ahb_master_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the maximum number of data-phase wait cycles (hready low) before the transfer is aborted; legal range 1..255.
REQ-002 Port hclk, input, 1: the only clock; all logic updates on its rising edge.
REQ-003 Port hreset, input, 1: synchronous, active-high reset.
REQ-004 Port cmd_valid, input, 1: the local requester presents a transfer command.
REQ-005 Port cmd_ready, output, 1: the block can accept a command this cycle.
REQ-006 Port cmd_write, input, 1: 1 = write, 0 = read.
REQ-007 Port cmd_addr, input, 32: transfer address.
REQ-008 Port cmd_wdata, input, 32: write data.
REQ-009 Port haddr, output, 32: AHB address.
REQ-010 Port hwrite, output, 1: AHB direction.
REQ-011 Port htrans, output, 2: AHB transfer type.
REQ-012 Port hsize, output, 3: AHB size; constant word (3'b010).
REQ-013 Port hwdata, output, 32: AHB write data.
REQ-014 Port hready, input, 1: bus ready from the slave mux.
REQ-015 Port hresp, input, 1: 1 = ERROR response.
REQ-016 Port hrdata, input, 32: read data.
REQ-017 Port rsp_valid, output, 1: one-cycle completion pulse.
REQ-018 Port rsp_rdata, output, 32: captured read data; held until the next completion.
REQ-019 Port rsp_error, output, 1: completion ended in an ERROR response or a timeout; valid with rsp_valid.

Function
REQ-020 The FSM SHALL have four states:
- IDLE
- ADDR (address phase)
- DATA (data phase)
- ERR (second cycle of the error response)
REQ-021 In IDLE:
- cmd_ready=1 and htrans=IDLE (2'b00).
- On cmd_valid=1, the command is registered and the FSM moves to ADDR on the next edge.
REQ-022 In all states other than IDLE, cmd_ready=0; only single NONSEQ transfers are issued and there is no back-to-back pipelining.
REQ-023 In ADDR:
- htrans=NONSEQ (2'b10); haddr and hwrite are driven from the registered command.
- On hready=1, the FSM moves to DATA.
- On hready=0, the address, direction and transfer type are held stable.
REQ-024 In DATA:
- htrans=IDLE; hwdata is driven from the registered write data and held stable until completion.
- The wait counter increments on each cycle with hready=0.
REQ-025 In DATA, hready=1 and hresp=0: rsp_valid=1 on the next cycle, rsp_error=0, rsp_rdata=hrdata for reads (unchanged for writes); FSM returns to IDLE.
REQ-026 In DATA, hready=0 and hresp=1: FSM moves to ERR.
REQ-027 In ERR, on hready=1: rsp_valid=1 and rsp_error=1 on the next cycle, FSM returns to IDLE, and rsp_rdata is unchanged.
REQ-028 In DATA or ERR, when the wait counter reaches TIMEOUT_CYCLES:
- The transfer is aborted and the FSM returns to IDLE.
- rsp_valid=1 and rsp_error=1 on the next cycle.
- Later hready/hresp activity for the aborted transfer is ignored.
REQ-029 The wait counter is 8-bit, clears on entry to ADDR, and saturates; it never wraps.
REQ-030 hready=1 and timeout in the same cycle: normal completion wins and the wait counter is ignored.
REQ-031 cmd_valid is sampled only in IDLE; cmd_* changes outside IDLE have no effect.

Reset
REQ-032 When hreset=1 at a rising edge, next cycle:
- FSM = IDLE; cmd_ready=1.
- htrans=2'b00; haddr=0, hwrite=0, hwdata=0, hsize=3'b010.
- rsp_valid=0, rsp_rdata=0, rsp_error=0; wait counter=0.
REQ-033 Reset asserted mid-transfer (ADDR, DATA or ERR) abandons the transfer with no rsp_valid pulse.

Structure
REQ-034 Shared package ahb_pkg holds:
- HTRANS codes: IDLE, BUSY, NONSEQ, SEQ.
- HSIZE_WORD.
- The master FSM state encoding.
REQ-035 The wait counter and timeout compare are one sub-module, ahb_wait_timer (inputs: clear, enable, limit; output: expired).

Verification
REQ-036 Write 0x0000_0008 with data 0xDEAD_BEEF, zero wait states:
- htrans=NONSEQ for 1 cycle.
- hwdata=0xDEAD_BEEF in the next cycle.
- rsp_valid one cycle later with rsp_error=0.
REQ-037 Read 0x0000_0005 with 2 wait cycles and hrdata=0x1234_5678: rsp_rdata=0x1234_5678 and rsp_valid after exactly 3 data-phase cycles.
REQ-038 Two-cycle ERROR (hready=0/hresp=1, then hready=1/hresp=1): FSM passes through ERR; rsp_error=1 and rsp_valid=1; cmd_ready returns to 1.
REQ-039 hready held 0 in DATA with TIMEOUT_CYCLES=4: abort after 4 wait cycles with rsp_error=1; a late hready=1 produces no second rsp_valid.
REQ-040 hreset=1 asserted in DATA: next cycle htrans=00, cmd_ready=1, no rsp_valid; a new command then completes normally.

Source files
------------

// File: rtl/ahb_pkg.sv
// ============================================================================
//  Module   : ahb_pkg
//  Purpose  : Shared AHB transfer codes and master FSM state encoding.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_ERR  = 2'd3
    } mstate_e;

endpackage

`default_nettype wire

// File: rtl/ahb_wait_timer.sv
// ============================================================================
//  Module   : ahb_wait_timer
//  Purpose  : Saturating 8-bit wait-state counter with limit compare.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ahb_wait_timer (
    input  logic       hclk,
    input  logic       hreset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count_q;

    always_ff @(posedge hclk) begin
        if (hreset || clear) begin
            count_q <= 8'd0;
        end else if (enable && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end
    end

    // Comparing the registered count lets a same-cycle hready=1 still complete normally.
    assign expired = (count_q >= limit);

endmodule

`default_nettype wire

// File: rtl/ahb_master_ctrl.sv
// ============================================================================
//  Module   : ahb_master_ctrl
//  Purpose  : Single-transfer AHB master with wait-state timeout.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ahb_master_ctrl
    import ahb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [1:0]  htrans,
    output logic [2:0]  hsize,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic        hresp,
    input  logic [31:0] hrdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam logic [7:0] c_limit = 8'(TIMEOUT_CYCLES);

    mstate_e     state_q;
    logic        cmd_ready_q;
    logic [1:0]  htrans_q;
    logic [31:0] haddr_q;
    logic        hwrite_q;
    logic [31:0] wdata_q;
    logic [31:0] hwdata_q;
    logic        rsp_valid_q;
    logic        rsp_error_q;
    logic [31:0] rsp_rdata_q;

    logic        w_tmr_clear;
    logic        w_tmr_enable;
    logic        w_expired;

    assign w_tmr_clear  = (state_q == S_IDLE) && cmd_valid;
    assign w_tmr_enable = ((state_q == S_DATA) || (state_q == S_ERR)) && !hready;

    ahb_wait_timer u_wait_timer (
        .hclk    (hclk),
        .hreset  (hreset),
        .clear   (w_tmr_clear),
        .enable  (w_tmr_enable),
        .limit   (c_limit),
        .expired (w_expired)
    );

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= 32'd0;
            hwrite_q    <= 1'b0;
            wdata_q     <= 32'd0;
            hwdata_q    <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        haddr_q     <= cmd_addr;
                        hwrite_q    <= cmd_write;
                        wdata_q     <= cmd_wdata;
                        htrans_q    <= HTRANS_NONSEQ;
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (hready) begin
                        hwdata_q <= wdata_q;
                        htrans_q <= HTRANS_IDLE;
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (hready) begin
                        if (!hwrite_q && !hresp) begin
                            rsp_rdata_q <= hrdata;
                        end
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= hresp;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (w_expired) begin
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (hresp) begin
                        state_q <= S_ERR;
                    end
                end
                S_ERR: begin
                    if (hready || w_expired) begin
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    htrans_q    <= HTRANS_IDLE;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign htrans    = htrans_q;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hsize     = HSIZE_WORD;
    assign hwdata    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_master_ctrl.sv
// ============================================================================
//  Module   : tb_ahb_master_ctrl
//  Purpose  : Directed self-checking bench for ahb_master_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ahb_master_ctrl;
    import ahb_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    ahb_master_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = 32'd0; cmd_wdata = 32'd0;
        hready = 1'b1; hresp = 1'b0; hrdata = 32'd0;
        tick(); tick();

        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_htrans",    32'(htrans),    32'd0);
        chk("rst_haddr",     haddr,          32'd0);
        chk("rst_hwrite",    32'(hwrite),    32'd0);
        chk("rst_hwdata",    hwdata,         32'd0);
        chk("rst_hsize",     32'(hsize),     32'd2);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata,      32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        hreset = 1'b0;
        tick();

        // Write 0x8 / 0xDEADBEEF, zero wait states
        issue(1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        chk("wr_addr_htrans", 32'(htrans),    32'd2);
        chk("wr_addr_haddr",  haddr,          32'h0000_0008);
        chk("wr_addr_hwrite", 32'(hwrite),    32'd1);
        chk("wr_addr_ready",  32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1; cmd_addr = 32'hFFFF_0000; cmd_wdata = 32'h1111_1111;
        tick();
        cmd_valid = 1'b0;
        chk("wr_data_htrans", 32'(htrans),    32'd0);
        chk("wr_data_hwdata", hwdata,         32'hDEAD_BEEF);
        chk("wr_data_haddr",  haddr,          32'h0000_0008);
        chk("wr_data_rspv",   32'(rsp_valid), 32'd0);
        tick();
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_error", 32'(rsp_error), 32'd0);
        chk("wr_rsp_ready", 32'(cmd_ready), 32'd1);
        tick();
        chk("wr_rsp_pulse", 32'(rsp_valid), 32'd0);

        // Read 0x5 with one address-phase stall and two data-phase waits
        hready = 1'b0;
        issue(1'b0, 32'h0000_0005, 32'd0);
        tick();
        chk("rd_addr_hold_htrans", 32'(htrans), 32'd2);
        chk("rd_addr_hold_haddr",  haddr,       32'h0000_0005);
        chk("rd_addr_hwrite",      32'(hwrite), 32'd0);
        hready = 1'b1;
        tick();
        hready = 1'b0; hrdata = 32'hAAAA_AAAA;
        tick();
        chk("rd_wait1_rspv", 32'(rsp_valid), 32'd0);
        tick();
        chk("rd_wait2_rspv", 32'(rsp_valid), 32'd0);
        hready = 1'b1; hrdata = 32'h1234_5678;
        tick();
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_rdata", rsp_rdata,      32'h1234_5678);
        chk("rd_rsp_error", 32'(rsp_error), 32'd0);
        hrdata = 32'd0;
        tick();

        // Two-cycle ERROR response on a read
        issue(1'b0, 32'h0000_0010, 32'd0);
        tick();
        hready = 1'b0; hresp = 1'b1; hrdata = 32'hBAD0_BAD0;
        tick();
        chk("err_state", 32'(dut.state_q), 32'(S_ERR));
        chk("err_rspv0", 32'(rsp_valid),   32'd0);
        hready = 1'b1;
        tick();
        hresp = 1'b0;
        chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("err_rsp_error", 32'(rsp_error), 32'd1);
        chk("err_rdata_kept", rsp_rdata,     32'h1234_5678);
        chk("err_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();

        // Timeout: hready held low in DATA, limit 4
        issue(1'b1, 32'h0000_0020, 32'h5555_AAAA);
        tick();
        hready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("to_wait%0d_rspv", i), 32'(rsp_valid), 32'd0);
        end
        tick();
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_error", 32'(rsp_error), 32'd1);
        chk("to_cmd_ready", 32'(cmd_ready), 32'd1);
        hready = 1'b1;
        tick();
        chk("to_late_rspv1", 32'(rsp_valid), 32'd0);
        tick();
        chk("to_late_rspv2", 32'(rsp_valid), 32'd0);

        // hready returns in the very cycle the limit is reached: normal completion
        issue(1'b0, 32'h0000_0030, 32'd0);
        tick();
        hready = 1'b0;
        tick(); tick(); tick(); tick();
        hready = 1'b1; hrdata = 32'hCAFE_F00D;
        tick();
        chk("edge_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("edge_rsp_error", 32'(rsp_error), 32'd0);
        chk("edge_rsp_rdata", rsp_rdata,      32'hCAFE_F00D);
        hrdata = 32'd0;
        tick();

        // Reset in DATA abandons the transfer silently
        issue(1'b1, 32'h0000_0040, 32'h0BAD_CAFE);
        tick();
        chk("rstd_in_data", 32'(dut.state_q), 32'(S_DATA));
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        chk("rstd_htrans",    32'(htrans),    32'd0);
        chk("rstd_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rstd_rspv",      32'(rsp_valid), 32'd0);
        chk("rstd_haddr",     haddr,          32'd0);
        tick();
        chk("rstd_rspv_after", 32'(rsp_valid), 32'd0);
        issue(1'b1, 32'h0000_0044, 32'h0F0F_0F0F);
        chk("post_htrans", 32'(htrans), 32'd2);
        tick();
        chk("post_hwdata", hwdata, 32'h0F0F_0F0F);
        tick();
        chk("post_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("post_rsp_error", 32'(rsp_error), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
